// File: rtl/stepper_pkg.sv
// stepper_pkg: types and constants shared by the stepper phase sequencer blocks.
`default_nettype none

package stepper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic CW  = 1'b1;
  localparam logic CCW = 1'b0;

  // Element 0 is the rightmost entry; even indices energize one coil, odd indices two.
  localparam logic [7:0][3:0] PHASE_TABLE = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0100, 4'b1100, 4'b1000
  };

endpackage

`default_nettype wire

// File: rtl/step_rate_divider.sv
// step_rate_divider: prescaler producing one tick per step period, with the period
// re-latched only at tick boundaries so a speed change never cuts an interval short.
`default_nettype none

module step_rate_divider #(
  parameter int BASE_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_i,
  input  logic       load_i,
  input  logic [1:0] speed_sel_i,
  output logic       tick_o
);

  localparam int PER_W = $clog2(BASE_DIV * 8) + 1;
  localparam logic [PER_W-1:0] RST_PERIOD = PER_W'(BASE_DIV * 8);

  logic [PER_W-1:0] period_q, period_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic [PER_W-1:0] speed_period;

  assign speed_period = PER_W'(BASE_DIV) << (2'd3 - speed_sel_i);
  assign tick_o       = run_i && (cnt_q == period_q - 1'b1);

  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    if (!run_i) begin
      cnt_d = '0;
      if (load_i) begin
        period_d = speed_period;
      end
    end else if (tick_o) begin
      cnt_d    = '0;
      period_d = speed_period;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      period_q <= RST_PERIOD;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/stepper_phase_sequencer.sv
// stepper_phase_sequencer: paced 4-coil phase sequencer with step strobe, signed
// position count and a dead-time after direction reversals.
`default_nettype none

module stepper_phase_sequencer
  import stepper_pkg::*;
#(
  parameter int BASE_DIV       = 50000,
  parameter int REV_HOLD_TICKS = 2,
  parameter int POS_W          = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    direction,
  input  logic                    half_step,
  input  logic [1:0]              speed_sel,
  output logic [3:0]              coils,
  output logic                    step_pulse,
  output logic signed [POS_W-1:0] position,
  output logic                    busy
);

  localparam int HOLD_W = (REV_HOLD_TICKS > 1) ? $clog2(REV_HOLD_TICKS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'((REV_HOLD_TICKS > 0) ? REV_HOLD_TICKS - 1 : 0);

  state_e                    state_q, state_d;
  logic [2:0]                idx_q, idx_d;
  logic                      last_dir_q, last_dir_d;
  logic [HOLD_W-1:0]         hold_cnt_q, hold_cnt_d;
  logic [3:0]                coils_q, coils_d;
  logic                      step_q, step_d;
  logic signed [POS_W-1:0]   pos_q, pos_d;
  logic                      tick;
  logic                      do_step;
  logic [2:0]                step_delta;
  logic [2:0]                idx_step;

  step_rate_divider #(
    .BASE_DIV (BASE_DIV)
  ) u_div (
    .clk         (clk),
    .reset       (reset),
    .run_i       (state_q != ST_IDLE),
    .load_i      ((state_q == ST_IDLE) && enable),
    .speed_sel_i (speed_sel),
    .tick_o      (tick)
  );

  // Full-step from an even index lands on the odd (two-coil) neighbour first.
  assign step_delta = (half_step || !idx_q[0]) ? 3'd1 : 3'd2;
  assign idx_step   = direction ? (idx_q + step_delta) : (idx_q - step_delta);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_dir_d = last_dir_q;
    hold_cnt_d = hold_cnt_q;
    coils_d    = coils_q;
    step_d     = 1'b0;
    pos_d      = pos_q;
    do_step    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        coils_d = '0;
        if (enable) begin
          state_d    = ST_RUN;
          coils_d    = PHASE_TABLE[idx_q];
          last_dir_d = direction;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
          coils_d = '0;
        end else if (tick) begin
          if ((direction == last_dir_q) || (REV_HOLD_TICKS == 0)) begin
            do_step    = 1'b1;
            last_dir_d = direction;
          end else begin
            state_d    = ST_HOLD;
            last_dir_d = direction;
            hold_cnt_d = '0;
          end
        end
      end
      ST_HOLD: begin
        if (!enable) begin
          state_d = ST_IDLE;
          coils_d = '0;
        end else if (tick) begin
          if (direction != last_dir_q) begin
            last_dir_d = direction;
            hold_cnt_d = '0;
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_d    = ST_RUN;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        coils_d = '0;
      end
    endcase

    if (do_step) begin
      idx_d   = idx_step;
      coils_d = PHASE_TABLE[idx_step];
      step_d  = 1'b1;
      pos_d   = direction ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      last_dir_q <= CW;
      hold_cnt_q <= '0;
      coils_q    <= '0;
      step_q     <= 1'b0;
      pos_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_dir_q <= last_dir_d;
      hold_cnt_q <= hold_cnt_d;
      coils_q    <= coils_d;
      step_q     <= step_d;
      pos_q      <= pos_d;
    end
  end

  assign coils      = coils_q;
  assign step_pulse = step_q;
  assign position   = pos_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_stepper_phase_sequencer.sv
// tb_stepper_phase_sequencer: directed scenarios plus random stimulus, checked every
// cycle against an interval/step-count reference model.
`default_nettype none

module tb_stepper_phase_sequencer;

  localparam int BASE_DIV = 4;
  localparam int REV_HOLD = 2;
  localparam int POS_W    = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             direction = 1'b1;
  logic             half_step = 1'b1;
  logic [1:0]       speed_sel = 2'd3;
  logic [3:0]       coils;
  logic             step_pulse;
  logic [POS_W-1:0] position;
  logic             busy;

  always #5 clk = ~clk;

  stepper_phase_sequencer #(
    .BASE_DIV       (BASE_DIV),
    .REV_HOLD_TICKS (REV_HOLD),
    .POS_W          (POS_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .direction  (direction),
    .half_step  (half_step),
    .speed_sel  (speed_sel),
    .coils      (coils),
    .step_pulse (step_pulse),
    .position   (position),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks time left in the current interval and ticks left in
  // the dead-time, and steps through the phase table with modular arithmetic.
  logic [3:0] tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                          4'b0010, 4'b0011, 4'b0001, 4'b1001};
  bit         m_run, m_hold, m_dir, m_pulse;
  int         m_left, m_holds, m_idx, m_pos;
  logic [3:0] m_coils;
  logic [31:0] m_pos_bits;

  function automatic int period_of(input logic [1:0] s);
    return BASE_DIV << (3 - int'(s));
  endfunction

  task automatic model_step(input bit d);
    int delta;
    delta   = (half_step || (m_idx % 2 == 0)) ? 1 : 2;
    m_idx   = (m_idx + (d ? delta : 8 - delta)) % 8;
    m_pos   = m_pos + (d ? 1 : -1);
    m_coils = tbl[m_idx];
    m_pulse = 1'b1;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run = 0; m_hold = 0; m_dir = 1; m_pulse = 0;
      m_left = 0; m_holds = 0; m_idx = 0; m_pos = 0; m_coils = 4'b0000;
    end else begin
      m_pulse = 1'b0;
      if (!m_run) begin
        m_coils = 4'b0000;
        if (enable) begin
          m_run = 1; m_hold = 0; m_dir = direction;
          m_coils = tbl[m_idx];
          m_left = period_of(speed_sel);
        end
      end else if (!enable) begin
        m_run = 0; m_hold = 0; m_coils = 4'b0000;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_left = period_of(speed_sel);
          if (m_hold) begin
            if (direction != m_dir) begin
              m_dir = direction; m_holds = REV_HOLD;
            end else begin
              m_holds--;
              if (m_holds == 0) m_hold = 0;
            end
          end else if (direction == m_dir || REV_HOLD == 0) begin
            m_dir = direction;
            model_step(direction);
          end else begin
            m_hold = 1; m_holds = REV_HOLD; m_dir = direction;
          end
        end
      end
    end
  end

  bit chk_on = 0;
  always @(negedge clk) begin
    if (chk_on) begin
      m_pos_bits = 32'(m_pos);
      check_val("coils", 32'(coils), 32'(m_coils));
      check_val("step_pulse", 32'(step_pulse), 32'(m_pulse));
      check_val("position", 32'(position), 32'(m_pos_bits[POS_W-1:0]));
      check_val("busy", 32'(busy), 32'(m_run));
    end
  end

  task automatic pulse_reset();
    reset = 1'b1; #1; reset = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    chk_on = 1;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;

    // idle after reset
    repeat (20) @(negedge clk);
    check_val("idle_coils", 32'(coils), 32'h0);
    check_val("idle_pos", 32'(position), 32'h0);
    check_val("idle_busy", 32'(busy), 32'h0);

    // half-step clockwise: 8 steps wrap back to index 0
    #1 enable = 1; direction = 1; half_step = 1; speed_sel = 3;
    repeat (33) @(negedge clk);
    check_val("hs_coils", 32'(coils), 32'h8);
    check_val("hs_pos", 32'(position), 32'h8);

    // full-step counter-clockwise from index 0
    #1 enable = 0; pulse_reset();
    direction = 0; half_step = 0; enable = 1;
    repeat (9) @(negedge clk);
    check_val("fs_coils2", 32'(coils), 32'h3);
    repeat (12) @(negedge clk);
    check_val("fs_coils5", 32'(coils), 32'h9);
    check_val("fs_pos", 32'(position), 32'hFFFB);

    // reversal dead-time from index 3
    #1 enable = 0; pulse_reset();
    direction = 1; half_step = 1; enable = 1;
    repeat (13) @(negedge clk);
    check_val("rev_pre_coils", 32'(coils), 32'h6);
    check_val("rev_pre_pos", 32'(position), 32'h3);
    @(negedge clk);
    #1 direction = 0;
    repeat (11) @(negedge clk);
    check_val("rev_hold_coils", 32'(coils), 32'h6);
    check_val("rev_hold_busy", 32'(busy), 32'h1);
    repeat (4) @(negedge clk);
    check_val("rev_step_coils", 32'(coils), 32'h4);
    check_val("rev_step_pos", 32'(position), 32'h2);
    check_val("rev_step_pulse", 32'(step_pulse), 32'h1);

    // speed change mid-interval
    @(negedge clk);
    #1 speed_sel = 1;
    repeat (3) @(negedge clk);
    check_val("spd_first_pulse", 32'(step_pulse), 32'h1);
    check_val("spd_first_coils", 32'(coils), 32'hC);
    repeat (15) @(negedge clk);
    check_val("spd_gap_pulse", 32'(step_pulse), 32'h0);
    @(negedge clk);
    check_val("spd_next_pulse", 32'(step_pulse), 32'h1);
    check_val("spd_next_coils", 32'(coils), 32'h8);

    // enable drop on the tick cycle, then resume at the retained index
    repeat (15) @(negedge clk);
    #1 enable = 0;
    @(negedge clk);
    check_val("drop_coils", 32'(coils), 32'h0);
    check_val("drop_pulse", 32'(step_pulse), 32'h0);
    check_val("drop_pos", 32'(position), 32'h0);
    check_val("drop_busy", 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    #1 enable = 1; direction = 1; speed_sel = 3;
    @(negedge clk);
    check_val("resume_coils", 32'(coils), 32'h8);
    repeat (9) @(negedge clk);
    check_val("resume_pos", 32'(position), 32'h2);

    // async reset in the middle of HOLD
    #1 direction = 0;
    for (int k = 0; k < 40 && !m_hold; k++) @(negedge clk);
    check_val("hold_reached", 32'(m_hold), 32'h1);
    check_val("hold_coils", 32'(coils), 32'h4);
    #1 reset = 1'b1;
    #1;
    check_val("rst_coils", 32'(coils), 32'h0);
    check_val("rst_pulse", 32'(step_pulse), 32'h0);
    check_val("rst_pos", 32'(position), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    #1 reset = 1'b0;

    // randomized operation
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(0, 999) < 3) pulse_reset();
      if (enable && $urandom_range(0, 99) < 2) enable = 0;
      else if (!enable && $urandom_range(0, 9) == 0) enable = 1;
      if ($urandom_range(0, 29) == 0) direction = ~direction;
      if ($urandom_range(0, 49) == 0) half_step = 1'($urandom);
      if ($urandom_range(0, 199) == 0) speed_sel = 2'($urandom_range(0, 3));
    end

    @(negedge clk);
    chk_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stepper_phase_sequencer.md
Name: stepper_phase_sequencer

Overview:
- Downstream consumer of the latched direction bit (1 = clockwise).
- Converts direction, enable, speed select and step mode into a paced 4-coil drive pattern for a unipolar/bipolar driver.
- Also provides a one-cycle step strobe and a signed position count.
- Enforces a dead-time on direction reversal so the motor is never stepped backwards on the tick immediately after a reversal.

Parameters:
- BASE_DIV, 50000, clocks per step at the fastest speed (speed_sel=3); must be >= 2.
- REV_HOLD_TICKS, 2, step ticks idled after a direction reversal; 0 disables the dead-time.
- POS_W, 16, width of the signed position counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  1 = run motor, 0 = de-energize
- direction  in  1  processed direction bit: 1 = clockwise (index +), 0 = counter-clockwise (index -)
- half_step  in  1  1 = 8-phase half-step, 0 = two-coil full-step
- speed_sel  in  2  step period = BASE_DIV << (3 - speed_sel)
- coils  out  4  coil drive {A,B,C,D}
- step_pulse  out  1  one-cycle strobe per executed step
- position  out  POS_W  signed step count, wraps modulo 2^POS_W
- busy  out  1  1 when state != IDLE

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, coils=0000, step_pulse=0, position=0, busy=0
  - phase index=0, last_dir=1
  - prescaler=0, hold counter=0
  - latched period = BASE_DIV<<3
- Phase table, index 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001. Even indices = one coil on; odd indices = two coils on.
- Prescaler:
  - Counts 0..period-1 while in RUN or HOLD; tick = (cnt == period-1), and cnt wraps to 0 on tick.
  - Held at 0 in IDLE.
  - Period is re-latched from speed_sel at each tick and on IDLE->RUN, so a speed change never truncates the current interval.
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - coils=0000.
  - If enable=1: next cycle state=RUN, coils=table[index], last_dir=direction, prescaler=0.
  - Index and position are retained across IDLE.
- RUN, on tick:
  - If direction == last_dir: step.
  - Else: enter HOLD, last_dir<=direction, hold counter<=0, no step.
  - If REV_HOLD_TICKS=0, a reversal steps immediately in the new direction with no HOLD.
- Step (same clock edge as tick):
  - Index update:
    - Half-step: index ±1 mod 8.
    - Full-step from an odd index: ±2 mod 8.
    - Full-step from an even index: ±1 mod 8, landing on an odd index.
  - coils<=table[new index]; step_pulse=1 for that one cycle.
  - position ±1 per step in either mode (one step = one table transition).
- HOLD:
  - coils hold their current pattern (energized).
  - Each tick increments the hold counter; on the REV_HOLD_TICKS-th tick, return to RUN with no step.
  - The first step in the new direction occurs at the next tick.
  - A direction toggle back during HOLD restarts the hold count and updates last_dir.
- enable=0 in any state: next cycle state=IDLE, coils=0000, step_pulse=0. A tick on that same cycle is ignored.
- Simultaneous events:
  - Enable drop beats tick.
  - A direction change on a non-tick cycle is evaluated only at the next tick.
- Asynchronous reset mid-run: all outputs take their reset values immediately.

Decomposition:
- Shared package stepper_pkg:
  - state enum (IDLE/RUN/HOLD)
  - 8-entry phase table constant
  - CW=1'b1 / CCW=1'b0 constants
- Natural sub-module: step_rate_divider (prescaler + period latch + tick output).
- FSM, phase indexing and position tracking live in the top block.

Test Plan:
All scenarios use BASE_DIV=4, REV_HOLD_TICKS=2, speed_sel=3, so period=4.
- Reset then idle: reset pulse, enable=0 for 20 cycles -> coils=0000, position=0, busy=0, step_pulse never asserted.
- Half-step CW run: enable=1 at cycle 0, direction=1, half_step=1 -> coils=1000 at cycle 1; steps every 4 cycles giving 1100, 0100, 0110, ...; after 8 steps coils=1000 and position=8.
- Full-step CCW from index 0: direction=0, half_step=0 -> coils sequence 1000, 1001, 0011, 0110, 1100, 1001; position=-5 after 5 steps.
- Reversal dead-time: running CW at index 3, flip direction to 0 between ticks -> next tick no step, 2 HOLD ticks with no step_pulse and coils=0110 held, then step to 0100 with position decremented.
- Speed change: speed_sel 3->1 mid-interval -> current step still lands 4 cycles after the previous one; subsequent steps spaced 16 cycles.
- Enable drop and async reset: enable=0 on a tick cycle -> no step, coils=0000 next cycle, and re-enable resumes at the retained index; assert reset mid-HOLD -> all outputs at reset values in the same cycle.
